smm_result_streamer: RTL and testbench

//   Reader side of the SMM1 result bus. Snapshots the flat C_out matrix (ELEMS x DATAWIDTH)
//   on a start pulse, then streams it out LANES elements per beat over a valid/ready

---
 rtl/smm_result_streamer_if.sv | 32 +++
 rtl/smm_result_streamer.sv | 97 +++++++++
 tb/tb_smm_result_streamer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/smm_result_streamer_if.sv
// Valid/ready beat stream carrying one or more matrix elements per beat.
// The beat index width is derived here so the producer and the consumer agree on it.
interface smm_result_streamer_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ELEMS     = 16,
    parameter int unsigned LANES     = 1
);
    localparam int unsigned BEATS = ELEMS / LANES;
    localparam int unsigned IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [DATAWIDTH*LANES-1:0] out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       out_last;
    logic [IDXW-1:0]            out_index;

    modport master (
        output out_data,
        output out_valid,
        output out_last,
        output out_index,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_valid,
        input  out_last,
        input  out_index,
        output out_ready
    );
endinterface

// File: rtl/smm_result_streamer.sv
// Snapshots the flat result matrix on start and streams it LANES elements per beat.
// Also publishes a per-element nonzero mask of the captured matrix.
module smm_result_streamer #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned ELEMS     = 16,
    parameter int unsigned LANES     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [DATAWIDTH*ELEMS-1:0] c_in,
    smm_result_streamer_if.master      stream,
    output logic                       busy,
    output logic                       done,
    output logic                       overrun,
    output logic [ELEMS-1:0]           nz_mask
);
    localparam int unsigned BEATS = ELEMS / LANES;
    localparam int unsigned IDXW  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [IDXW-1:0] LastBeat = IDXW'(BEATS - 1);

    typedef enum logic {StIdle, StStream} state_e;

    state_e                                state_q;
    logic [BEATS-1:0][DATAWIDTH*LANES-1:0] hold_q;
    logic [IDXW-1:0]                       beat_q;
    logic [ELEMS-1:0]                      nz_q;
    logic                                  done_q;
    logic                                  overrun_q;
    logic [ELEMS-1:0]                      nz_next;
    logic                                  last_beat;
    logic                                  last_accept;

    always_comb begin
        nz_next = '0;
        for (int j = 0; j < ELEMS; j++) begin
            nz_next[j] = |c_in[j*DATAWIDTH +: DATAWIDTH];
        end
    end

    assign last_beat   = (beat_q == LastBeat);
    assign last_accept = stream.out_ready && last_beat;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            beat_q    <= '0;
            nz_q      <= '0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        hold_q  <= c_in;
                        nz_q    <= nz_next;
                        beat_q  <= '0;
                        state_q <= StStream;
                    end
                end
                StStream: begin
                    if (stream.out_ready) begin
                        if (last_beat) begin
                            done_q <= 1'b1;
                            // A start landing on the final handshake chains the next matrix
                            if (start) begin
                                hold_q <= c_in;
                                nz_q   <= nz_next;
                                beat_q <= '0;
                            end else begin
                                state_q <= StIdle;
                            end
                        end else begin
                            beat_q <= beat_q + IDXW'(1);
                        end
                    end
                    if (start && !last_accept) begin
                        overrun_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Payload comes only from the snapshot, never from the live bus
    assign stream.out_data  = hold_q[beat_q];
    assign stream.out_valid = (state_q == StStream);
    assign stream.out_last  = (state_q == StStream) && last_beat;
    assign stream.out_index = beat_q;
    assign busy             = (state_q == StStream);
    assign done             = done_q;
    assign overrun          = overrun_q;
    assign nz_mask          = nz_q;
endmodule

// File: tb/tb_smm_result_streamer.sv
// Directed bench for smm_result_streamer with a LANES=1 and a LANES=4 instance.
module tb_smm_result_streamer;
    localparam int unsigned DW = 32;
    localparam int unsigned EL = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst1, rst4, start1, start4;
    logic [DW*EL-1:0] c1, c4;
    logic            busy1, done1, ovr1, busy4, done4, ovr4;
    logic [EL-1:0]   nz1, nz4;

    smm_result_streamer_if #(.DATAWIDTH(DW), .ELEMS(EL), .LANES(1)) s1 ();
    smm_result_streamer_if #(.DATAWIDTH(DW), .ELEMS(EL), .LANES(4)) s4 ();

    smm_result_streamer #(.DATAWIDTH(DW), .ELEMS(EL), .LANES(1)) u_dut1 (
        .clk     (clk),
        .rst     (rst1),
        .start   (start1),
        .c_in    (c1),
        .stream  (s1),
        .busy    (busy1),
        .done    (done1),
        .overrun (ovr1),
        .nz_mask (nz1)
    );

    smm_result_streamer #(.DATAWIDTH(DW), .ELEMS(EL), .LANES(4)) u_dut4 (
        .clk     (clk),
        .rst     (rst4),
        .start   (start4),
        .c_in    (c4),
        .stream  (s4),
        .busy    (busy4),
        .done    (done4),
        .overrun (ovr4),
        .nz_mask (nz4)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW*EL-1:0] ramp(input logic [31:0] base);
        logic [DW*EL-1:0] v;
        for (int j = 0; j < EL; j++) v[j*DW +: DW] = base + 32'(j);
        return v;
    endfunction

    task automatic check_idle1(input string tag);
        check(tag, {s1.out_valid, s1.out_last, busy1, done1, ovr1, s1.out_index, nz1,
                    s1.out_data}, '0);
    endtask

    task automatic check_idle4(input string tag);
        check(tag, {s4.out_valid, s4.out_last, busy4, done4, ovr4, s4.out_index, nz4,
                    s4.out_data}, '0);
    endtask

    initial begin
        logic [127:0] exp4;
        int b;
        int cyc;

        rst1 = 1'b0; rst4 = 1'b0; start1 = 1'b0; start4 = 1'b0;
        c1 = '0; c4 = '0; s1.out_ready = 1'b0; s4.out_ready = 1'b0;

        // 1: reset and idle, out_ready high has no effect
        #2;
        check_idle1("t1_in_reset1");
        check_idle4("t1_in_reset4");
        step();
        rst1 = 1'b1; rst4 = 1'b1;
        s1.out_ready = 1'b1; s4.out_ready = 1'b1;
        c1 = ramp(32'h55);
        for (int i = 0; i < 20; i++) begin
            step();
            check_idle1("t1_idle1");
        end
        check_idle4("t1_idle4");

        // 2: basic stream
        c1 = ramp(32'd1);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("t2_valid", s1.out_valid, 1);
            check("t2_data", s1.out_data, 32'(i + 1));
            check("t2_index", s1.out_index, i);
            check("t2_last", s1.out_last, i == 15);
            check("t2_done", done1, 0);
            step();
        end
        check("t2_done_pulse", done1, 1);
        check("t2_valid_drop", s1.out_valid, 0);
        check("t2_busy_drop", busy1, 0);
        check("t2_nz", nz1, 16'hFFFF);
        step();
        check("t2_done_clear", done1, 0);
        check("t2_nz_hold", nz1, 16'hFFFF);

        // 3: backpressure, live bus changes after capture, one zero element
        c1 = ramp(32'h100);
        c1[3*DW +: DW] = '0;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        c1 = '1;
        b = 0;
        cyc = 0;
        while (b < 16 && cyc < 100) begin
            s1.out_ready = (cyc % 2 == 0);
            check("t3_data", s1.out_data, (b == 3) ? 32'h0 : 32'h100 + 32'(b));
            check("t3_index", s1.out_index, b);
            check("t3_valid", s1.out_valid, 1);
            step();
            if (s1.out_ready) b++;
            cyc++;
        end
        check("t3_timeout", cyc < 100, 1);
        check("t3_done", done1, 1);
        check("t3_nz", nz1, 16'hFFF7);
        s1.out_ready = 1'b1;
        step();

        // 4: overrun, second start at beat 5 must not disturb the stream
        c1 = ramp(32'h200);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                start1 = 1'b1;
                c1 = '0;
            end else begin
                start1 = 1'b0;
            end
            check("t4_data", s1.out_data, 32'h200 + 32'(i));
            check("t4_ovr", ovr1, i > 5);
            step();
        end
        start1 = 1'b0;
        check("t4_done", done1, 1);
        check("t4_nz", nz1, 16'hFFFF);
        repeat (3) step();
        check("t4_ovr_sticky", ovr1, 1);
        rst1 = 1'b0;
        #1;
        check("t4_ovr_reset", ovr1, 0);
        step();
        rst1 = 1'b1;

        // 5: back-to-back capture on the final handshake
        c1 = ramp(32'h10);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                start1 = 1'b1;
                c1 = {EL{32'hA5}};
            end
            check("t5_data_a", s1.out_data, 32'h10 + 32'(i));
            step();
            start1 = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            check("t5_valid", s1.out_valid, 1);
            check("t5_done", done1, i == 0);
            check("t5_data_b", s1.out_data, 32'hA5);
            check("t5_index", s1.out_index, i);
            step();
        end
        check("t5_done_end", done1, 1);
        check("t5_valid_end", s1.out_valid, 0);
        check("t5_ovr", ovr1, 0);
        step();

        // 6a: LANES=1 async reset at beat 7
        c1 = ramp(32'd1);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        repeat (7) step();
        check("t6_index7", s1.out_index, 7);
        rst1 = 1'b0;
        #1;
        check_idle1("t6_async1");
        step();
        check("t6_no_done1", done1, 0);
        rst1 = 1'b1;
        step();
        check("t6_stay_idle1", s1.out_valid, 0);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        check("t6_restart_data1", s1.out_data, 32'd1);
        check("t6_restart_index1", s1.out_index, 0);

        // 6b: LANES=4 stream, then async reset mid-stream
        c4 = ramp(32'd1);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int l = 0; l < 4; l++) exp4[l*DW +: DW] = 32'(4 * i + l + 1);
            check("t6_data4", s4.out_data, exp4);
            check("t6_index4", s4.out_index, i);
            check("t6_last4", s4.out_last, i == 3);
            check("t6_valid4", s4.out_valid, 1);
            step();
        end
        check("t6_done4", done4, 1);
        check("t6_nz4", nz4, 16'hFFFF);
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        step();
        step();
        check("t6_index4_mid", s4.out_index, 2);
        rst4 = 1'b0;
        #1;
        check_idle4("t6_async4");
        step();
        check("t6_no_done4", done4, 0);
        rst4 = 1'b1;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("t6_restart_data4", s4.out_data, {32'd4, 32'd3, 32'd2, 32'd1});
        check("t6_restart_index4", s4.out_index, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
